axi_sram_slave: RTL and testbench
=================================

AXI_SRAM_SLAVE -- requirements
Module: axi_sram_slave

Interface
REQ-001 SHALL provide parameter BASE, default 64'h0004_0000, first byte address decoded by the slave.
REQ-002 SHALL provide parameter LENGTH, default 64'h04000, size of the region in bytes; a multiple of 8 and a power of two.
REQ-003 SHALL provide parameter AXI_ID_WIDTH, default 4, width of all ID fields.
REQ-004 clk_i  input  1  single clock, all logic rising-edge.
REQ-005 rst_i  input  1  synchronous active-high reset.
REQ-006 io_axi_s_awid  input  AXI_ID_WIDTH  write address ID.
REQ-007 io_axi_s_awaddr  input  64  write burst start byte address.
REQ-008 io_axi_s_awlen  input  8  write beats minus one.
REQ-009 io_axi_s_awburst  input  2  write burst type.
REQ-010 io_axi_s_awvalid  input  1  write address valid.
REQ-011 io_axi_s_awready  output  1  write address accepted.
REQ-012 io_axi_s_wdata  input  64  write beat data.
REQ-013 io_axi_s_wstrb  input  8  byte enables, bit n for bits 8n+7:8n.
REQ-014 io_axi_s_wlast  input  1  final write beat marker.
REQ-015 io_axi_s_wvalid  input  1  write data valid.
REQ-016 io_axi_s_wready  output  1  write data accepted.
REQ-017 io_axi_s_bid  output  AXI_ID_WIDTH  captured awid.
REQ-018 io_axi_s_bresp  output  2  write response code.
REQ-019 io_axi_s_bvalid  output  1  write response valid.
REQ-020 io_axi_s_bready  input  1  master accepts response.
REQ-021 io_axi_s_arid  input  AXI_ID_WIDTH  read address ID.
REQ-022 io_axi_s_araddr  input  64  read burst start byte address.
REQ-023 io_axi_s_arlen  input  8  read beats minus one.
REQ-024 io_axi_s_arburst  input  2  read burst type.
REQ-025 io_axi_s_arvalid  input  1  read address valid.
REQ-026 io_axi_s_arready  output  1  read address accepted.
REQ-027 io_axi_s_rid  output  AXI_ID_WIDTH  captured arid.
REQ-028 io_axi_s_rdata  output  64  read beat data.
REQ-029 io_axi_s_rresp  output  2  read response code.
REQ-030 io_axi_s_rlast  output  1  final read beat marker.
REQ-031 io_axi_s_rvalid  output  1  read data valid.
REQ-032 io_axi_s_rready  input  1  master accepts read beat.

Function
REQ-033 The slave SHALL implement FSM IDLE/RD/WR/BRESP with one transaction outstanding; size, lock, cache, prot, qos, region, user and atop are not ported, and every beat is a full 8-byte word with writes qualified by wstrb.
REQ-034 In IDLE, arready=1 and awready=!arvalid (read wins simultaneous requests); the handshake captures id, addr, len, burst, clears the 8-bit beat counter and the sticky error, and moves to RD or WR; readys are 0 outside IDLE.
REQ-035 Storage SHALL be LENGTH/8 words of 64 bits, uninitialised, indexed by (addr-BASE)>>3.
REQ-036 RD: rvalid=1 from the cycle after the AR handshake; rdata/rresp/rlast/rid SHALL hold stable while rvalid&&!rready; each rvalid&&rready advances one beat (one beat/cycle when rready=1); rlast=1 exactly when counter==len; last handshake returns to IDLE.
REQ-037 WR: wready=1; each wvalid handshake writes bytes enabled by wstrb; the beat where counter==len moves to BRESP regardless of wlast; wlast!=(counter==len) on any beat sets sticky SLVERR while still performing the write.
REQ-038 BRESP: bvalid=1, bresp=sticky code (DECERR over SLVERR over OKAY), bid=captured id, held until bready, then IDLE.
REQ-039 Burst INCR adds 8 to the beat address per beat (64-bit wrap); FIXED keeps it; WRAP and reserved respond SLVERR on every beat, suppress writes, return rdata=0.

Reset
REQ-040 While rst_i=1 at a clock edge the FSM SHALL enter IDLE, all valids and readys read 0 during reset, bresp/rresp/rdata/rid/bid clear to 0, memory is preserved; a burst in flight is abandoned with no further beats or response.

Configuration
REQ-041 With AXI_SRAM_SLV_RANGE_CHECK_EN defined, a beat address outside [BASE, BASE+LENGTH) SHALL give DECERR (rdata=0, write dropped); undefined, the index is taken modulo LENGTH/8 and the response is OKAY.

Verification
REQ-042 Write BASE+0x10 len=0 wdata=0xDEADBEEF_CAFEF00D wstrb=0xFF, then read it -> bresp=00, rdata equal, rlast=1, rid=arid.
REQ-043 INCR read len=3 from BASE with rready toggling 1,0,1 -> four beats at BASE..BASE+0x18, rlast only on beat 4, data stable during stalls.
REQ-044 arvalid and awvalid raised in the same IDLE cycle -> arready=1, awready=0; write accepted the cycle after the read's last beat handshake.
REQ-045 Word holding 0xFFFFFFFF_FFFFFFFF written with wdata=0x00000000_12345678 wstrb=0x0F -> read returns 0xFFFFFFFF_12345678.
REQ-046 Read araddr=BASE+LENGTH -> rresp=11, rdata=0 with macro; rresp=00 and word 0 data without it.
REQ-047 rst_i pulsed during beat 2 of a len=7 read -> rvalid=0 in the following cycle, arready=1 the cycle after rst_i drops.

Source files
------------

// File: rtl/axi_sram_slave.sv
// axi_sram_slave: single-outstanding AXI4 slave in front of a 64-bit wide SRAM array.
// Define AXI_SRAM_SLV_RANGE_CHECK_EN to answer DECERR for beats outside [BASE, BASE+LENGTH).
module axi_sram_slave #(
    parameter logic [63:0] BASE         = 64'h0004_0000,
    parameter logic [63:0] LENGTH       = 64'h04000,
    parameter int          AXI_ID_WIDTH = 4
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic [AXI_ID_WIDTH-1:0] io_axi_s_awid,
    input  logic [63:0]             io_axi_s_awaddr,
    input  logic [7:0]              io_axi_s_awlen,
    input  logic [1:0]              io_axi_s_awburst,
    input  logic                    io_axi_s_awvalid,
    output logic                    io_axi_s_awready,
    input  logic [63:0]             io_axi_s_wdata,
    input  logic [7:0]              io_axi_s_wstrb,
    input  logic                    io_axi_s_wlast,
    input  logic                    io_axi_s_wvalid,
    output logic                    io_axi_s_wready,
    output logic [AXI_ID_WIDTH-1:0] io_axi_s_bid,
    output logic [1:0]              io_axi_s_bresp,
    output logic                    io_axi_s_bvalid,
    input  logic                    io_axi_s_bready,
    input  logic [AXI_ID_WIDTH-1:0] io_axi_s_arid,
    input  logic [63:0]             io_axi_s_araddr,
    input  logic [7:0]              io_axi_s_arlen,
    input  logic [1:0]              io_axi_s_arburst,
    input  logic                    io_axi_s_arvalid,
    output logic                    io_axi_s_arready,
    output logic [AXI_ID_WIDTH-1:0] io_axi_s_rid,
    output logic [63:0]             io_axi_s_rdata,
    output logic [1:0]              io_axi_s_rresp,
    output logic                    io_axi_s_rlast,
    output logic                    io_axi_s_rvalid,
    input  logic                    io_axi_s_rready
);
    localparam int unsigned WORDS = 32'(LENGTH >> 3);
    localparam int          IDX_W = $clog2(WORDS);
`ifdef AXI_SRAM_SLV_RANGE_CHECK_EN
    localparam bit RANGE_CHECK = 1'b1;
`else
    localparam bit RANGE_CHECK = 1'b0;
`endif
    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    // Encoding order lets "worst response wins" be a plain numeric max.
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [1:0] {IDLE, RD, WR, BRESP} state_t;

    state_t                  state;
    logic [AXI_ID_WIDTH-1:0] id_q;
    logic [63:0]             addr_q;
    logic [7:0]              len_q;
    logic [7:0]              cnt_q;
    logic [1:0]              burst_q;
    logic [1:0]              err_q;
    logic                    rvalid_q;
    logic                    bvalid_q;
    logic [63:0]             mem [WORDS];

    logic [63:0] next_addr;
    logic [63:0] rd_addr;
    logic [63:0] rd_word;
    logic [1:0]  rd_burst;
    logic [1:0]  rd_resp;
    logic [1:0]  wr_resp;
    logic [1:0]  wr_err;
    logic [1:0]  err_next;
    logic        ar_fire;
    logic        aw_fire;
    logic        r_fire;
    logic        w_fire;
    logic        mem_we;

    function automatic logic [IDX_W-1:0] word_idx(input logic [63:0] a);
        return IDX_W'((a - BASE) >> 3);
    endfunction

    function automatic logic [1:0] beat_resp(input logic [63:0] a, input logic [1:0] burst);
        if (RANGE_CHECK && ((a - BASE) >= LENGTH)) return RESP_DECERR;
        if (burst != BURST_FIXED && burst != BURST_INCR) return RESP_SLVERR;
        return RESP_OKAY;
    endfunction

    assign io_axi_s_arready = (state == IDLE) && !rst_i;
    assign io_axi_s_awready = (state == IDLE) && !io_axi_s_arvalid && !rst_i;
    assign io_axi_s_wready  = (state == WR) && !rst_i;
    assign io_axi_s_rvalid  = rvalid_q && !rst_i;
    assign io_axi_s_bvalid  = bvalid_q && !rst_i;

    assign ar_fire = io_axi_s_arvalid && io_axi_s_arready;
    assign aw_fire = io_axi_s_awvalid && io_axi_s_awready;
    assign r_fire  = io_axi_s_rvalid && io_axi_s_rready;
    assign w_fire  = io_axi_s_wvalid && io_axi_s_wready;
    assign mem_we  = w_fire && (wr_resp == RESP_OKAY);

    // NOTE: every variable gets a value on every path through always_comb, so no latch is inferred.
    always_comb begin
        next_addr = (burst_q == BURST_INCR) ? addr_q + 64'd8 : addr_q;
        rd_addr   = (state == IDLE) ? io_axi_s_araddr : next_addr;
        rd_burst  = (state == IDLE) ? io_axi_s_arburst : burst_q;
        rd_resp   = beat_resp(rd_addr, rd_burst);
        rd_word   = (rd_resp == RESP_OKAY) ? mem[word_idx(rd_addr)] : 64'd0;
        wr_resp   = beat_resp(addr_q, burst_q);
        wr_err    = (io_axi_s_wlast != (cnt_q == len_q)) ? RESP_SLVERR : RESP_OKAY;
        if (wr_resp > wr_err) wr_err = wr_resp;
        err_next  = (wr_err > err_q) ? wr_err : err_q;
    end

    // NOTE: the array has no reset so it can map onto SRAM and keep its contents across rst_i.
    always_ff @(posedge clk_i) begin
        if (mem_we) begin
            for (int b = 0; b < 8; b++) begin
                if (io_axi_s_wstrb[b]) mem[word_idx(addr_q)][8*b +: 8] <= io_axi_s_wdata[8*b +: 8];
            end
        end
    end

    // NOTE: non-blocking assignments keep every register sampling pre-edge values.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state          <= IDLE;
            id_q           <= '0;
            addr_q         <= '0;
            len_q          <= '0;
            cnt_q          <= '0;
            burst_q        <= '0;
            err_q          <= RESP_OKAY;
            rvalid_q       <= 1'b0;
            bvalid_q       <= 1'b0;
            io_axi_s_rid   <= '0;
            io_axi_s_rdata <= '0;
            io_axi_s_rresp <= RESP_OKAY;
            io_axi_s_rlast <= 1'b0;
            io_axi_s_bid   <= '0;
            io_axi_s_bresp <= RESP_OKAY;
        end else begin
            case (state)
                IDLE: begin
                    if (ar_fire) begin
                        state          <= RD;
                        id_q           <= io_axi_s_arid;
                        addr_q         <= io_axi_s_araddr;
                        len_q          <= io_axi_s_arlen;
                        burst_q        <= io_axi_s_arburst;
                        cnt_q          <= '0;
                        err_q          <= RESP_OKAY;
                        rvalid_q       <= 1'b1;
                        io_axi_s_rid   <= io_axi_s_arid;
                        io_axi_s_rdata <= rd_word;
                        io_axi_s_rresp <= rd_resp;
                        io_axi_s_rlast <= (io_axi_s_arlen == 8'd0);
                    end else if (aw_fire) begin
                        state   <= WR;
                        id_q    <= io_axi_s_awid;
                        addr_q  <= io_axi_s_awaddr;
                        len_q   <= io_axi_s_awlen;
                        burst_q <= io_axi_s_awburst;
                        cnt_q   <= '0;
                        err_q   <= RESP_OKAY;
                    end
                end
                RD: begin
                    if (r_fire) begin
                        if (cnt_q == len_q) begin
                            state    <= IDLE;
                            rvalid_q <= 1'b0;
                        end else begin
                            cnt_q          <= cnt_q + 8'd1;
                            addr_q         <= next_addr;
                            io_axi_s_rdata <= rd_word;
                            io_axi_s_rresp <= rd_resp;
                            io_axi_s_rlast <= (cnt_q + 8'd1 == len_q);
                        end
                    end
                end
                WR: begin
                    if (w_fire) begin
                        err_q <= err_next;
                        if (cnt_q == len_q) begin
                            state          <= BRESP;
                            bvalid_q       <= 1'b1;
                            io_axi_s_bresp <= err_next;
                            io_axi_s_bid   <= id_q;
                        end else begin
                            cnt_q  <= cnt_q + 8'd1;
                            addr_q <= next_addr;
                        end
                    end
                end
                BRESP: begin
                    if (io_axi_s_bready) begin
                        state    <= IDLE;
                        bvalid_q <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_axi_sram_slave.sv
// tb_axi_sram_slave: scoreboard bench for axi_sram_slave; expectations come from a word-level memory model.
module tb_axi_sram_slave;
    localparam logic [63:0] BASE   = 64'h0004_0000;
    localparam logic [63:0] LENGTH = 64'h4000;
    localparam int          IDW    = 4;
    localparam int unsigned WORDS  = 32'(LENGTH >> 3);
    localparam int          BUDGET = 20;
    localparam logic [1:0]  FIXED = 2'b00, INCR = 2'b01, WRAP = 2'b10, RSVD = 2'b11;
    localparam logic [1:0]  OKAY = 2'b00, SLVERR = 2'b10, DECERR = 2'b11;

    logic           clk, rst;
    logic [IDW-1:0] awid, arid, bid, rid;
    logic [63:0]    awaddr, araddr, wdata, rdata;
    logic [7:0]     awlen, arlen, wstrb;
    logic [1:0]     awburst, arburst, bresp, rresp;
    logic           awvalid, awready, wlast, wvalid, wready, bvalid, bready;
    logic           arvalid, arready, rlast, rvalid, rready;

    axi_sram_slave #(.BASE(BASE), .LENGTH(LENGTH), .AXI_ID_WIDTH(IDW)) dut (
        .clk_i(clk), .rst_i(rst),
        .io_axi_s_awid(awid), .io_axi_s_awaddr(awaddr), .io_axi_s_awlen(awlen),
        .io_axi_s_awburst(awburst), .io_axi_s_awvalid(awvalid), .io_axi_s_awready(awready),
        .io_axi_s_wdata(wdata), .io_axi_s_wstrb(wstrb), .io_axi_s_wlast(wlast),
        .io_axi_s_wvalid(wvalid), .io_axi_s_wready(wready),
        .io_axi_s_bid(bid), .io_axi_s_bresp(bresp), .io_axi_s_bvalid(bvalid), .io_axi_s_bready(bready),
        .io_axi_s_arid(arid), .io_axi_s_araddr(araddr), .io_axi_s_arlen(arlen),
        .io_axi_s_arburst(arburst), .io_axi_s_arvalid(arvalid), .io_axi_s_arready(arready),
        .io_axi_s_rid(rid), .io_axi_s_rdata(rdata), .io_axi_s_rresp(rresp),
        .io_axi_s_rlast(rlast), .io_axi_s_rvalid(rvalid), .io_axi_s_rready(rready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct { logic [63:0] data; logic [1:0] resp; logic last; logic [IDW-1:0] id; } rd_exp_t;
    typedef struct { logic [1:0] resp; logic [IDW-1:0] id; } wr_exp_t;

    rd_exp_t     rd_q[$];
    wr_exp_t     wr_q[$];
    logic [63:0] mdl [int unsigned];
    logic [63:0] wbuf [16];
    logic [7:0]  sbuf [16];
    int          n_pass = 0;
    int          n_total = 0;

    function automatic logic [1:0] worse(input logic [1:0] a, input logic [1:0] b);
        return (a > b) ? a : b;
    endfunction

    function automatic int unsigned widx(input logic [63:0] a);
        return 32'(((a - BASE) >> 3) % 64'(WORDS));
    endfunction

    function automatic logic [1:0] model_resp(input logic [63:0] a, input logic [1:0] burst);
`ifdef AXI_SRAM_SLV_RANGE_CHECK_EN
        if ((a - BASE) >= LENGTH) return DECERR;
`endif
        if (burst == WRAP || burst == RSVD) return SLVERR;
        return OKAY;
    endfunction

    task automatic plan_write(input logic [IDW-1:0] id, input logic [63:0] addr, input logic [7:0] len,
                              input logic [1:0] burst, input int wlast_at);
        logic [63:0] a, w;
        logic [1:0]  r, err;
        wr_exp_t     e;
        a = addr;
        err = OKAY;
        for (int b = 0; b <= int'(len); b++) begin
            r = model_resp(a, burst);
            if (r == OKAY) begin
                w = mdl.exists(widx(a)) ? mdl[widx(a)] : 64'd0;
                for (int k = 0; k < 8; k++) if (sbuf[b][k]) w[8*k +: 8] = wbuf[b][8*k +: 8];
                mdl[widx(a)] = w;
            end
            if ((b == wlast_at) != (b == int'(len))) r = worse(r, SLVERR);
            err = worse(err, r);
            if (burst == INCR) a = a + 64'd8;
        end
        e.resp = err;
        e.id = id;
        wr_q.push_back(e);
    endtask

    task automatic plan_read(input logic [IDW-1:0] id, input logic [63:0] addr, input logic [7:0] len,
                             input logic [1:0] burst);
        logic [63:0] a;
        rd_exp_t     e;
        a = addr;
        for (int b = 0; b <= int'(len); b++) begin
            e.resp = model_resp(a, burst);
            e.data = (e.resp == OKAY) ? mdl[widx(a)] : 64'd0;
            e.last = (b == int'(len));
            e.id = id;
            rd_q.push_back(e);
            if (burst == INCR) a = a + 64'd8;
        end
    endtask

    task automatic send_ar(input logic [IDW-1:0] id, input logic [63:0] addr, input logic [7:0] len,
                           input logic [1:0] burst, input string tag);
        int n = 0;
        arid = id; araddr = addr; arlen = len; arburst = burst; arvalid = 1'b1;
        while (arready !== 1'b1 && n < BUDGET) begin @(posedge clk); #1; n++; end
        n_total++;
        if (arready !== 1'b1) $display("FAIL %s ar_handshake: arready=%b after %0d cycles, required 1", tag, arready, n);
        else n_pass++;
        @(posedge clk); #1;
        arvalid = 1'b0;
    endtask

    task automatic send_aw(input logic [IDW-1:0] id, input logic [63:0] addr, input logic [7:0] len,
                           input logic [1:0] burst, input string tag);
        int n = 0;
        awid = id; awaddr = addr; awlen = len; awburst = burst; awvalid = 1'b1;
        while (awready !== 1'b1 && n < BUDGET) begin @(posedge clk); #1; n++; end
        n_total++;
        if (awready !== 1'b1) $display("FAIL %s aw_handshake: awready=%b after %0d cycles, required 1", tag, awready, n);
        else n_pass++;
        @(posedge clk); #1;
        awvalid = 1'b0;
    endtask

    task automatic send_w(input logic [7:0] len, input int wlast_at, input string tag);
        int n;
        for (int b = 0; b <= int'(len); b++) begin
            wdata = wbuf[b]; wstrb = sbuf[b]; wlast = (b == wlast_at); wvalid = 1'b1;
            n = 0;
            while (wready !== 1'b1 && n < BUDGET) begin @(posedge clk); #1; n++; end
            n_total++;
            if (wready !== 1'b1) $display("FAIL %s w_beat%0d: wready=%b, required 1", tag, b, wready);
            else n_pass++;
            @(posedge clk); #1;
        end
        wvalid = 1'b0;
        wlast = 1'b0;
    endtask

    task automatic recv_b(input int bdelay, input string tag);
        int n = 0;
        wr_exp_t e;
        bready = 1'b0;
        while (bvalid !== 1'b1 && n < BUDGET) begin @(posedge clk); #1; n++; end
        repeat (bdelay) begin @(posedge clk); #1; end
        e = wr_q.pop_front();
        n_total++;
        if ({bvalid, bresp, bid} !== {1'b1, e.resp, e.id})
            $display("FAIL %s bresp: got valid=%b resp=%b id=%h, required valid=1 resp=%b id=%h",
                     tag, bvalid, bresp, bid, e.resp, e.id);
        else n_pass++;
        bready = 1'b1;
        @(posedge clk); #1;
        bready = 1'b0;
        n_total++;
        if (bvalid !== 1'b0) $display("FAIL %s bvalid_drop: got %b, required 0", tag, bvalid);
        else n_pass++;
    endtask

    task automatic recv_r(input logic [2:0] rpat, input string tag);
        int      cyc = 0;
        bit      held = 0;
        logic [63+2+1+IDW:0] hold_v;
        rd_exp_t e;
        n_total++;
        if (rvalid !== 1'b1) $display("FAIL %s rvalid_first: got %b, required 1", tag, rvalid);
        else n_pass++;
        while (rd_q.size() > 0 && cyc < 100) begin
            rready = rpat[cyc % 3];
            if (held) begin
                n_total++;
                if ({rdata, rresp, rlast, rid} !== hold_v)
                    $display("FAIL %s stall_hold: got %h, required %h", tag, {rdata, rresp, rlast, rid}, hold_v);
                else n_pass++;
            end
            held = 0;
            if (rvalid === 1'b1 && rready) begin
                e = rd_q.pop_front();
                n_total++;
                if ({rdata, rresp, rlast, rid} !== {e.data, e.resp, e.last, e.id})
                    $display("FAIL %s beat: got data=%h resp=%b last=%b id=%h, required data=%h resp=%b last=%b id=%h",
                             tag, rdata, rresp, rlast, rid, e.data, e.resp, e.last, e.id);
                else n_pass++;
            end else if (rvalid === 1'b1) begin
                held = 1;
                hold_v = {rdata, rresp, rlast, rid};
            end
            @(posedge clk); #1;
            cyc++;
        end
        rready = 1'b0;
        n_total++;
        if (rd_q.size() != 0 || rvalid !== 1'b0) begin
            $display("FAIL %s r_end: %0d beats outstanding, rvalid=%b, required 0 and 0", tag, rd_q.size(), rvalid);
            rd_q.delete();
        end else n_pass++;
    endtask

    task automatic axi_write(input logic [IDW-1:0] id, input logic [63:0] addr, input logic [7:0] len,
                             input logic [1:0] burst, input int wlast_at, input int bdelay, input string tag);
        plan_write(id, addr, len, burst, wlast_at);
        send_aw(id, addr, len, burst, tag);
        send_w(len, wlast_at, tag);
        recv_b(bdelay, tag);
    endtask

    task automatic axi_read(input logic [IDW-1:0] id, input logic [63:0] addr, input logic [7:0] len,
                            input logic [1:0] burst, input logic [2:0] rpat, input string tag);
        plan_read(id, addr, len, burst);
        send_ar(id, addr, len, burst, tag);
        recv_r(rpat, tag);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_total++;
        if ({arready, awready, wready, rvalid, bvalid} !== 5'b0)
            $display("FAIL reset_handshakes: got %b, required 00000", {arready, awready, wready, rvalid, bvalid});
        else n_pass++;
        n_total++;
        if ({rdata, rresp, rid, bid, bresp} !== '0)
            $display("FAIL reset_outputs: got rdata=%h rresp=%b rid=%h bid=%h bresp=%b, required all 0",
                     rdata, rresp, rid, bid, bresp);
        else n_pass++;
        rst = 1'b0;
        @(posedge clk); #1;
        n_total++;
        if ({arready, awready, wready, rvalid, bvalid} !== 5'b11000)
            $display("FAIL reset_idle: got %b, required 11000", {arready, awready, wready, rvalid, bvalid});
        else n_pass++;
    endtask

    task automatic test_single();
        wbuf[0] = 64'hDEADBEEF_CAFEF00D; sbuf[0] = 8'hFF;
        axi_write(4'h3, BASE + 64'h10, 8'd0, INCR, 0, 0, "single_wr");
        axi_read(4'h5, BASE + 64'h10, 8'd0, INCR, 3'b111, "single_rd");
    endtask

    task automatic test_fill();
        for (int i = 0; i < 8; i++) begin
            wbuf[i] = {32'hF00D_0000 + 32'(i), 32'h1000_0001 * 32'(i + 1)};
            sbuf[i] = 8'hFF;
        end
        axi_write(4'hA, BASE, 8'd7, INCR, 7, 2, "fill_wr");
    endtask

    task automatic test_incr_stall();
        axi_read(4'h9, BASE, 8'd3, INCR, 3'b101, "incr_stall");
    endtask

    task automatic test_strobe();
        wbuf[0] = 64'hFFFFFFFF_FFFFFFFF; sbuf[0] = 8'hFF;
        axi_write(4'h1, BASE + 64'h40, 8'd0, INCR, 0, 0, "strobe_pre");
        wbuf[0] = 64'h00000000_12345678; sbuf[0] = 8'h0F;
        axi_write(4'h2, BASE + 64'h40, 8'd0, INCR, 0, 0, "strobe_wr");
        axi_read(4'h4, BASE + 64'h40, 8'd0, INCR, 3'b111, "strobe_rd");
    endtask

    task automatic test_collision();
        plan_read(4'h1, BASE, 8'd1, INCR);
        wbuf[0] = 64'hA5A5_5A5A_0F0F_F0F0; sbuf[0] = 8'hFF;
        plan_write(4'h2, BASE + 64'h108, 8'd0, INCR, 0);
        arid = 4'h1; araddr = BASE; arlen = 8'd1; arburst = INCR; arvalid = 1'b1;
        awid = 4'h2; awaddr = BASE + 64'h108; awlen = 8'd0; awburst = INCR; awvalid = 1'b1;
        #1;
        n_total++;
        if ({arready, awready} !== 2'b10) $display("FAIL collide_ready: got %b, required 10", {arready, awready});
        else n_pass++;
        @(posedge clk); #1;
        arvalid = 1'b0;
        #1;
        n_total++;
        if (awready !== 1'b0) $display("FAIL collide_aw_blocked: got %b, required 0", awready);
        else n_pass++;
        recv_r(3'b111, "collide_rd");
        n_total++;
        if (awready !== 1'b1) $display("FAIL collide_aw_after: got %b, required 1", awready);
        else n_pass++;
        @(posedge clk); #1;
        awvalid = 1'b0;
        send_w(8'd0, 0, "collide_wr");
        recv_b(0, "collide_wr");
        axi_read(4'h6, BASE + 64'h108, 8'd0, INCR, 3'b111, "collide_chk");
    endtask

    task automatic test_bursts();
        wbuf[0] = 64'h1111_2222_3333_4444; sbuf[0] = 8'hFF;
        wbuf[1] = 64'hAAAA_BBBB_CCCC_DDDD; sbuf[1] = 8'hF0;
        axi_write(4'h7, BASE + 64'h80, 8'd1, FIXED, 1, 0, "fixed_wr");
        axi_read(4'h7, BASE + 64'h80, 8'd1, FIXED, 3'b111, "fixed_rd");
        wbuf[0] = 64'h0123_4567_89AB_CDEF; sbuf[0] = 8'hFF;
        axi_write(4'h8, BASE + 64'h88, 8'd0, INCR, 0, 0, "wrap_pre");
        wbuf[0] = 64'hFFFF_0000_FFFF_0000; wbuf[1] = 64'h0000_FFFF_0000_FFFF; sbuf[1] = 8'hFF;
        axi_write(4'h8, BASE + 64'h88, 8'd1, WRAP, 1, 0, "wrap_wr");
        axi_read(4'h8, BASE + 64'h88, 8'd0, INCR, 3'b111, "wrap_kept");
        axi_read(4'hB, BASE, 8'd1, WRAP, 3'b111, "wrap_rd");
        axi_read(4'hC, BASE, 8'd0, RSVD, 3'b111, "rsvd_rd");
        wbuf[0] = 64'h5151_5151_0000_0001; wbuf[1] = 64'h5252_5252_0000_0002;
        axi_write(4'hD, BASE + 64'h90, 8'd1, INCR, 0, 0, "wlast_early");
        axi_read(4'hD, BASE + 64'h90, 8'd1, INCR, 3'b111, "wlast_early_rd");
        wbuf[0] = 64'h6666_7777_8888_9999;
        axi_write(4'hE, BASE + 64'h20, 8'd0, INCR, -1, 0, "wlast_missing");
    endtask

    task automatic test_out_of_range();
        axi_read(4'h2, BASE + LENGTH, 8'd0, INCR, 3'b111, "oor_rd");
        wbuf[0] = 64'h5555_AAAA_5555_AAAA; sbuf[0] = 8'hFF;
        axi_write(4'h3, BASE + LENGTH + 64'h8, 8'd0, INCR, 0, 0, "oor_wr");
        axi_read(4'h3, BASE + 64'h8, 8'd0, INCR, 3'b111, "oor_alias");
    endtask

    task automatic test_reset_midburst();
        rd_exp_t e;
        plan_read(4'hF, BASE, 8'd7, INCR);
        send_ar(4'hF, BASE, 8'd7, INCR, "rst_mid");
        rready = 1'b1;
        e = rd_q.pop_front();
        n_total++;
        if ({rvalid, rdata, rlast} !== {1'b1, e.data, e.last})
            $display("FAIL rst_mid_beat1: got valid=%b data=%h last=%b, required valid=1 data=%h last=%b",
                     rvalid, rdata, rlast, e.data, e.last);
        else n_pass++;
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        n_total++;
        if ({rvalid, arready} !== 2'b00) $display("FAIL rst_mid_during: got rvalid,arready=%b, required 00", {rvalid, arready});
        else n_pass++;
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        n_total++;
        if ({rvalid, arready, rdata, rid} !== {2'b01, 64'd0, 4'd0})
            $display("FAIL rst_mid_after: got rvalid=%b arready=%b rdata=%h rid=%h, required 0 1 0 0", rvalid, arready, rdata, rid);
        else n_pass++;
        @(posedge clk); #1;
        n_total++;
        if ({rvalid, arready} !== 2'b01) $display("FAIL rst_mid_next: got rvalid,arready=%b, required 01", {rvalid, arready});
        else n_pass++;
        rready = 1'b0;
        rd_q.delete();
        axi_read(4'h4, BASE + 64'h18, 8'd1, INCR, 3'b111, "rst_mem_kept");
    endtask

    initial begin
        rst = 1'b1;
        awid = '0; awaddr = '0; awlen = '0; awburst = '0; awvalid = 1'b0;
        wdata = '0; wstrb = '0; wlast = 1'b0; wvalid = 1'b0; bready = 1'b0;
        arid = '0; araddr = '0; arlen = '0; arburst = '0; arvalid = 1'b0; rready = 1'b0;
        test_reset();
        test_single();
        test_fill();
        test_incr_stall();
        test_strobe();
        test_collision();
        test_bursts();
        test_out_of_range();
        test_reset_midburst();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running at %0t, required completion", $time);
        $fatal(1, "watchdog expired");
    end
endmodule
